com_bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared snoop bus (Address_Com / Data_Bus_Com) used by the four per-core cache controllers.
- Grants exclusive bus ownership to one requester at a time and holds the grant while that requester keeps its request high.
- Inserts a one-cycle turnaround between owners.
- Forcibly revokes ownership after a bounded hold time so a hung controller cannot starve the other cores.

---
 rtl/com_bus_arbiter_pkg.sv | 17 +
 rtl/com_bus_arbiter_rr_priority_pick.sv | 35 +++
 rtl/com_bus_arbiter.sv | 116 +++++++++++
 tb/tb_com_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/com_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// com_bus_arbiter_pkg
// Shared definitions for the snoop-bus arbiters: core count, arbiter FSM
// state encodings and the default maximum hold time.
// ---------------------------------------------------------------------------
package com_bus_arbiter_pkg;

    localparam int NUM_CORES        = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GRANT = 2'b01,
        ARB_TURN  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/com_bus_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. Searches req starting at ptr and
// wrapping modulo 4; reports the first set bit.
//   req   : per-core request vector
//   ptr   : index searched first
//   valid : at least one request is set
//   idx   : index of the winning core (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import com_bus_arbiter_pkg::*;
(
    input  logic [NUM_CORES-1:0] req,
    input  logic [1:0]           ptr,
    output logic                 valid,
    output logic [1:0]           idx
);

    logic [1:0] probe;

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        probe = 2'd0;
        for (int i = 0; i < NUM_CORES; i++) begin
            // 2-bit add wraps 3 -> 0 naturally
            probe = ptr + 2'(i);
            if (!valid && req[probe]) begin
                valid = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// ---------------------------------------------------------------------------
// com_bus_arbiter
// Round-robin arbiter for the shared snoop bus. One owner at a time, grant
// held while the owner keeps requesting, one idle turnaround cycle between
// owners, and forced revocation after MAX_HOLD consecutive grant cycles.
//   clk          : block clock, rising edge
//   rst          : asynchronous active-high reset
//   Com_Bus_Req  : per-core request (bit i = core i)
//   Com_Bus_Gnt  : registered one-hot grant, zero when bus is free
//   Bus_Owner    : index of granted core, 0 when no grant
//   Bus_Busy     : high whenever any grant is asserted
//   Hold_Timeout : one-cycle pulse in the cycle after a forced revocation
// ---------------------------------------------------------------------------
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_CORES,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] Com_Bus_Req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt,
    output logic [1:0]         Bus_Owner,
    output logic               Bus_Busy,
    output logic               Hold_Timeout
);

    arb_state_t         state_q, state_n;
    logic [1:0]         rr_ptr_q, rr_ptr_n;
    logic [CNT_W-1:0]   hold_q, hold_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic [1:0]         owner_q, owner_n;
    logic               busy_q;
    logic               to_q, to_n;

    logic               pick_vld;
    logic [1:0]         pick_idx;

    rr_priority_pick u_pick (
        .req   (Com_Bus_Req),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= 2'd0;
            hold_q   <= '0;
            gnt_q    <= '0;
            owner_q  <= 2'd0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            rr_ptr_q <= rr_ptr_n;
            hold_q   <= hold_n;
            gnt_q    <= gnt_n;
            owner_q  <= owner_n;
            busy_q   <= |gnt_n;
            to_q     <= to_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        rr_ptr_n = rr_ptr_q;
        hold_n   = hold_q;
        gnt_n    = gnt_q;
        owner_n  = owner_q;
        to_n     = 1'b0;

        case (state_q)
            ARB_GRANT: begin
                // Non-owner requests are deliberately not looked at here.
                if (!Com_Bus_Req[owner_q] || (hold_q == CNT_W'(MAX_HOLD - 1))) begin
                    state_n  = ARB_TURN;
                    gnt_n    = '0;
                    owner_n  = 2'd0;
                    hold_n   = '0;
                    // Move past the departing owner so a hog that keeps
                    // requesting only wins again when nobody else asks.
                    rr_ptr_n = owner_q + 2'd1;
                    to_n     = Com_Bus_Req[owner_q];
                end else begin
                    hold_n = hold_q + CNT_W'(1);
                end
            end

            // IDLE, TURN (and any illegal encoding) arbitrate identically;
            // TURN is guaranteed one grant-free cycle because the grant it
            // produces only becomes visible after the next edge.
            default: begin
                gnt_n   = '0;
                owner_n = 2'd0;
                hold_n  = '0;
                if (pick_vld) begin
                    state_n         = ARB_GRANT;
                    gnt_n[pick_idx] = 1'b1;
                    owner_n         = pick_idx;
                end else begin
                    state_n = ARB_IDLE;
                end
            end
        endcase
    end

    assign Com_Bus_Gnt  = gnt_q;
    assign Bus_Owner    = owner_q;
    assign Bus_Busy     = busy_q;
    assign Hold_Timeout = to_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_com_bus_arbiter
// Table of per-cycle vectors plus hand-written multi-cycle sequences for the
// round-robin snoop-bus arbiter. Expected outputs are queued when a request
// vector is driven and compared one clock later.
// ---------------------------------------------------------------------------
module tb_com_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tout;

    int n_tests = 0;
    int n_fail  = 0;

    com_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .Com_Bus_Req  (req),
        .Com_Bus_Gnt  (gnt),
        .Bus_Owner    (owner),
        .Bus_Busy     (busy),
        .Hold_Timeout (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       tout;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       tout;
        string      name;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic t);
        vec_t v;
        v.do_rst = r; v.req = rq; v.gnt = g; v.tout = t;
        vq.push_back(v);
    endtask

    task automatic compare(input exp_t e);
        n_tests++;
        if (gnt !== e.gnt || owner !== e.owner || busy !== e.busy || tout !== e.tout) begin
            n_fail++;
            $display("FAIL %s t=%0t: got gnt=%b owner=%0d busy=%b to=%b, want gnt=%b owner=%0d busy=%b to=%b",
                     e.name, $time, gnt, owner, busy, tout, e.gnt, e.owner, e.busy, e.tout);
        end
    endtask

    // Drive one request vector, queue its expectation, check after the edge.
    task automatic cycle(input logic [3:0] rq, input logic [3:0] g, input logic t, input string nm);
        exp_t e;
        e.gnt = g; e.owner = idx_of(g); e.busy = |g; e.tout = t; e.name = nm;
        sb.push_back(e);
        req = rq;
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    // Reset pulse placed between clock edges (caller sits at posedge+1).
    task automatic pulse_reset();
        req = 4'b0000;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    // Invariants: one-hot grant, no owner change without a zero cycle.
    logic [3:0] prev_gnt = 4'b0000;
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL onehot t=%0t: got gnt=%b, want at most one bit", $time, gnt);
            end
            if (prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt) begin
                n_fail++;
                $display("FAIL gap t=%0t: gnt went %b -> %b, want a zero cycle between", $time, prev_gnt, gnt);
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        logic [3:0] g;
        int pos;

        // Reset state while rst is held
        #12;
        e0.gnt = 4'b0; e0.owner = 2'd0; e0.busy = 1'b0; e0.tout = 1'b0; e0.name = "reset_state";
        compare(e0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- Table: single request, then round robin with 3-cycle holds ----
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0100, 4'b0100, 0);
        add(0, 4'b0100, 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 0);   // TURN
        add(0, 4'b0000, 4'b0000, 0);   // IDLE
        add(1, 4'b1111, 4'b0001, 0);   // reset first: rr_ptr back to 0
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1101, 4'b0000, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1011, 4'b0000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b0111, 4'b0000, 0);
        add(0, 4'b1111, 4'b0001, 0);   // wrapped back to core 0
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0);
        foreach (vq[i]) begin
            if (vq[i].do_rst) pulse_reset();
            cycle(vq[i].req, vq[i].gnt, vq[i].tout, $sformatf("vec%0d", i));
        end

        // ---- Timeout: core 1 alone holds Req for 40 cycles ----
        pulse_reset();
        for (int t = 1; t <= 40; t++) begin
            pos = (t - 1) % 17;
            g = (pos < 16) ? 4'b0010 : 4'b0000;
            cycle(4'b0010, g, (pos == 16), $sformatf("timeout_c%0d", t));
        end
        cycle(4'b0000, 4'b0000, 0, "timeout_release");
        cycle(4'b0000, 4'b0000, 0, "timeout_idle");

        // ---- Timeout with contention: core 2 joins at cycle 3 ----
        pulse_reset();
        for (int t = 1; t <= 18; t++) begin
            g = (t <= 16) ? 4'b0010 : (t == 17) ? 4'b0000 : 4'b0100;
            cycle((t >= 3) ? 4'b0110 : 4'b0010, g, (t == 17), $sformatf("contend_c%0d", t));
        end
        cycle(4'b0000, 4'b0000, 0, "contend_release");
        cycle(4'b0000, 4'b0000, 0, "contend_idle");

        // ---- Async reset mid-grant ----
        pulse_reset();
        cycle(4'b1000, 4'b1000, 0, "async_pre");
        #2 rst = 1'b1;
        #1;
        e0.gnt = 4'b0; e0.owner = 2'd0; e0.busy = 1'b0; e0.tout = 1'b0; e0.name = "async_immediate";
        compare(e0);
        #2 rst = 1'b0;
        cycle(4'b1001, 4'b0001, 0, "async_core0_first");
        cycle(4'b0000, 4'b0000, 0, "async_release");
        cycle(4'b0000, 4'b0000, 0, "async_idle");

        // ---- Simultaneous release by 2 and request by 3 ----
        pulse_reset();
        cycle(4'b0100, 4'b0100, 0, "handoff_g2");
        cycle(4'b1000, 4'b0000, 0, "handoff_turn");
        cycle(4'b1000, 4'b1000, 0, "handoff_g3");
        cycle(4'b0000, 4'b0000, 0, "handoff_rel3");
        cycle(4'b1111, 4'b0001, 0, "handoff_ptr0");
        cycle(4'b0000, 4'b0000, 0, "handoff_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
